regfile_wb_pipe: RTL and testbench
==================================

Name: regfile_wb_pipe

Overview:
- Parametrised successor of the decode-stage register file, adding write-back ports and reset behaviour.
- Sits between the decode stage (two combinational read ports, srcA/srcB) and the write-back stage (two synchronous write ports, dstE/dstM).
- Adds a configurable write-to-read bypass, a write-back stall gate and a committed-write counter for debug and performance.

Parameters:
- DATA_W, 64, register data width in bits.
- ADDR_W, 4, register index width; index 2^ADDR_W-1 is the NONE code.
- NREG, 15, number of physical registers; legal range 1 .. 2^ADDR_W-1.
- RESET_IDX, 1, if 1 register k resets to value k; if 0 all registers reset to 0.
- BYPASS, 1, if 1 a read of a register being written this cycle returns the write data.
- CNT_W, 32, width of the committed-write counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- d_srcA_i  in  ADDR_W  read index A.
- d_srcB_i  in  ADDR_W  read index B.
- d_valA_o  out  DATA_W  read data A.
- d_valB_o  out  DATA_W  read data B.
- W_dstE_i  in  ADDR_W  write index, E port.
- W_valE_i  in  DATA_W  write data, E port.
- W_dstM_i  in  ADDR_W  write index, M port.
- W_valM_i  in  DATA_W  write data, M port.
- W_stall_i  in  1  when 1, suppresses both writes this cycle.
- wr_cnt_o  out  CNT_W  number of register writes committed since reset.

Behaviour:
- Reset (rst_i=1, asynchronous):
  - Register k (0..NREG-1) := k if RESET_IDX=1, else 0.
  - wr_cnt_o := 0.
  - All writes are ignored while rst_i is high.
  - Reset asserted mid-operation overrides any write on the same edge.
- Read (combinational, zero latency):
  - d_valX_o = 0 if srcX = NONE or srcX >= NREG.
  - Otherwise d_valX_o = the register contents, subject to bypass.
  - During reset the outputs reflect the reset values.
- Write port enable:
  - A port is enabled iff dst != NONE, dst < NREG, W_stall_i=0 and rst_i=0.
  - Indices >= NREG that are not NONE are silently dropped and are not counted.
- Write timing: the register updates on the rising edge; the new value is visible to a non-bypassed read in the following cycle.
- Same-register collision: if W_dstE_i = W_dstM_i and both ports are enabled, the M port wins (Y86 popq %rsp semantics). The counter increments by 1 only.
- Bypass, BYPASS=1:
  - If srcX equals an enabled write index, d_valX_o returns that port's write data in the same cycle.
  - If both ports match, valM is returned.
  - When W_stall_i=1 no bypass occurs.
- BYPASS=0: reads always return the stored contents (old value during the write cycle).
- Counter:
  - wr_cnt_o += number of distinct registers written on the edge (0, 1 or 2).
  - Wraps modulo 2^CNT_W with no saturation.
- No X propagation: every output is defined for every input combination after reset.
- Elaboration check: NREG > 2^ADDR_W-1 is a fatal parameter error.

Test Plan:
- Reset: pulse rst_i with no clock edge, read all indices 0..14 and 0xF -> d_valA_o = index (0xF -> 0); wr_cnt_o = 0 (RESET_IDX=1).
- Basic write: W_dstE=3, valE=0xDEAD, W_dstM=NONE, one edge -> next cycle d_srcA=3 gives 0xDEAD and wr_cnt_o = 1. With BYPASS=1, the same cycle also gives 0xDEAD; with BYPASS=0 it gives 3.
- Collision: dstE=dstM=4, valE=0x11, valM=0x22, edge -> reg4 = 0x22; wr_cnt_o increments by 1; bypassed read of 4 during the write cycle = 0x22.
- Dual write plus stall:
  - dstE=1/0xAA and dstM=2/0xBB with W_stall_i=1 -> registers unchanged, wr_cnt_o unchanged.
  - Deassert the stall -> reg1 = 0xAA, reg2 = 0xBB, wr_cnt_o += 2.
- Out-of-range and NONE: dst=0xF and, with NREG=12, dst=13 -> no register changes, counter unchanged, reads of 13 return 0.
- Async reset mid-write: assert rst_i between edges while dstE=5/0x55 is pending -> reg5 = 5 immediately, and stays 5 after the next edge while rst_i is held high.

Source files
------------

// File: rtl/regfile_wb_pipe.sv
// regfile_wb_pipe
// Register file that sits between the decode stage and the write-back stage.
// Decode reads two registers combinationally. Write-back writes up to two
// registers on each rising clock edge. The block also provides an optional
// write-to-read bypass, a stall gate for write-back, and a counter of
// committed register writes.
//
// Ports:
//   clk_i      clock; all state changes on the rising edge
//   rst_i      asynchronous active-high reset
//   d_srcA_i   read index A        d_valA_o  read data A
//   d_srcB_i   read index B        d_valB_o  read data B
//   W_dstE_i   E-port write index  W_valE_i  E-port write data
//   W_dstM_i   M-port write index  W_valM_i  M-port write data
//   W_stall_i  suppresses both writes (and bypass) this cycle
//   wr_cnt_o   number of distinct register writes committed since reset
module regfile_wb_pipe #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 4,
    parameter int NREG      = 15,
    parameter int RESET_IDX = 1,
    parameter int BYPASS    = 1,
    parameter int CNT_W     = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] d_srcA_i,
    input  logic [ADDR_W-1:0] d_srcB_i,
    output logic [DATA_W-1:0] d_valA_o,
    output logic [DATA_W-1:0] d_valB_o,
    input  logic [ADDR_W-1:0] W_dstE_i,
    input  logic [DATA_W-1:0] W_valE_i,
    input  logic [ADDR_W-1:0] W_dstM_i,
    input  logic [DATA_W-1:0] W_valM_i,
    input  logic              W_stall_i,
    output logic [CNT_W-1:0]  wr_cnt_o
);

    // The all-ones index is reserved as "no register". The extra top bit
    // lets an index be compared against NREG without truncating NREG.
    localparam logic [ADDR_W-1:0] NONE_IDX = '1;
    localparam logic [ADDR_W:0]   NREG_L   = NREG[ADDR_W:0];

    // An illegal register count is caught when the design is elaborated.
    if (NREG < 1 || NREG > (2 ** ADDR_W) - 1) begin : g_badNreg
        $fatal(1, "regfile_wb_pipe: NREG must be in 1 .. 2^ADDR_W-1");
    end

    logic [DATA_W-1:0] regs [NREG];
    logic [CNT_W-1:0]  wrCnt;
    logic              enE;
    logic              enM;
    logic [1:0]        incr;

    // Port enables. Reset is included here as well as in the flops, so that
    // the bypass path cannot show write data while the file is held in reset.
    always_comb begin
        enE = (W_dstE_i != NONE_IDX) && ({1'b0, W_dstE_i} < NREG_L) && !W_stall_i && !rst_i;
        enM = (W_dstM_i != NONE_IDX) && ({1'b0, W_dstM_i} < NREG_L) && !W_stall_i && !rst_i;
    end

    // Count distinct registers written. When both ports hit the same
    // register, that counts as a single write.
    always_comb begin
        incr = 2'd0;
        if (enE && enM && (W_dstE_i == W_dstM_i)) begin
            incr = 2'd1;
        end else begin
            incr = {1'b0, enE} + {1'b0, enM};
        end
    end

    // Storage update. The M port is applied after the E port, so M wins when
    // both ports target the same register (popq %rsp behaviour). The loop
    // compares each entry against the index rather than indexing directly,
    // which keeps the array depth independent of the index width.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NREG; k++) begin
                regs[k] <= (RESET_IDX != 0) ? DATA_W'(k) : '0;
            end
            wrCnt <= '0;
        end else begin
            for (int k = 0; k < NREG; k++) begin
                if (enE && (W_dstE_i == ADDR_W'(k))) begin
                    regs[k] <= W_valE_i;
                end
                if (enM && (W_dstM_i == ADDR_W'(k))) begin
                    regs[k] <= W_valM_i;
                end
            end
            wrCnt <= wrCnt + CNT_W'(incr);
        end
    end

    // Read lookup. NONE and out-of-range indices return zero. Bypass gives
    // priority to the M port so that reads match what the storage will hold
    // after the edge.
    function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] src);
        logic [DATA_W-1:0] v;
        v = '0;
        if ((src != NONE_IDX) && ({1'b0, src} < NREG_L)) begin
            for (int k = 0; k < NREG; k++) begin
                if (src == ADDR_W'(k)) begin
                    v = regs[k];
                end
            end
            if (BYPASS != 0) begin
                if (enE && (src == W_dstE_i)) begin
                    v = W_valE_i;
                end
                if (enM && (src == W_dstM_i)) begin
                    v = W_valM_i;
                end
            end
        end
        return v;
    endfunction

    // Both decode read ports use the same lookup.
    always_comb begin
        d_valA_o = readPort(d_srcA_i);
        d_valB_o = readPort(d_srcB_i);
    end

    assign wr_cnt_o = wrCnt;

endmodule

// File: tb/tb_regfile_wb_pipe.sv
// tb_regfile_wb_pipe
// Directed testbench for regfile_wb_pipe. Two instances share the same
// stimulus:
//   dut1  default configuration (NREG=15, bypass on, registers reset to
//         their own index)
//   dut2  NREG=12, bypass off, registers reset to zero
// Using both instances exercises the out-of-range write path, the non-bypassed
// read path and both reset styles.
`timescale 1ns/1ps
module tb_regfile_wb_pipe;

    localparam logic [3:0] NONE = 4'hF;

    logic        clk;
    logic        rst;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [3:0]  dstE;
    logic [63:0] valE;
    logic [3:0]  dstM;
    logic [63:0] valM;
    logic        stall;

    logic [63:0] valA1;
    logic [63:0] valB1;
    logic [31:0] cnt1;
    logic [63:0] valA2;
    logic [63:0] valB2;
    logic [31:0] cnt2;

    int checks;
    int failures;

    regfile_wb_pipe dut1 (
        .clk_i     (clk),
        .rst_i     (rst),
        .d_srcA_i  (srcA),
        .d_srcB_i  (srcB),
        .d_valA_o  (valA1),
        .d_valB_o  (valB1),
        .W_dstE_i  (dstE),
        .W_valE_i  (valE),
        .W_dstM_i  (dstM),
        .W_valM_i  (valM),
        .W_stall_i (stall),
        .wr_cnt_o  (cnt1)
    );

    regfile_wb_pipe #(
        .NREG      (12),
        .RESET_IDX (0),
        .BYPASS    (0)
    ) dut2 (
        .clk_i     (clk),
        .rst_i     (rst),
        .d_srcA_i  (srcA),
        .d_srcB_i  (srcB),
        .d_valA_o  (valA2),
        .d_valB_o  (valB2),
        .W_dstE_i  (dstE),
        .W_valE_i  (valE),
        .W_dstM_i  (dstM),
        .W_valM_i  (valM),
        .W_stall_i (stall),
        .wr_cnt_o  (cnt2)
    );

    // Free-running clock. Rising edges occur at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog: stop the run if it fails to finish.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                                 input logic [3:0] de, input logic [63:0] ve,
                                 input logic [3:0] dm, input logic [63:0] vm,
                                 input logic st);
        srcA  = a;
        srcB  = b;
        dstE  = de;
        valE  = ve;
        dstM  = dm;
        valM  = vm;
        stall = st;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge, then let the outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        applyStimulus(4'd0, 4'd0, NONE, 64'd0, NONE, 64'd0, 1'b0);

        // Pulse reset with no clock edge inside the pulse.
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        #0.5;
        for (int i = 0; i < 16; i++) begin
            srcA = 4'(i);
            srcB = 4'(i);
            #0.1;
            checkOutput($sformatf("rst_val1_%0d", i), valA1, (i == 15) ? 64'd0 : 64'(i));
            checkOutput($sformatf("rst_val2_%0d", i), valB2, 64'd0);
        end
        checkOutput("rst_cnt1", {32'd0, cnt1}, 64'd0);
        checkOutput("rst_cnt2", {32'd0, cnt2}, 64'd0);

        // Basic write to register 3 through the E port.
        tick();
        applyStimulus(4'd3, 4'd3, 4'd3, 64'hDEAD, NONE, 64'd0, 1'b0);
        #1;
        checkOutput("basic_byp1", valA1, 64'hDEAD);
        checkOutput("basic_nobyp2", valA2, 64'd0);
        tick();
        applyStimulus(4'd3, 4'd3, NONE, 64'd0, NONE, 64'd0, 1'b0);
        #1;
        checkOutput("basic_rd1", valA1, 64'hDEAD);
        checkOutput("basic_rd2", valA2, 64'hDEAD);
        checkOutput("basic_cnt1", {32'd0, cnt1}, 64'd1);
        checkOutput("basic_cnt2", {32'd0, cnt2}, 64'd1);

        // Both ports write register 4; the M port must win.
        applyStimulus(4'd4, 4'd4, 4'd4, 64'h11, 4'd4, 64'h22, 1'b0);
        #1;
        checkOutput("coll_byp1", valA1, 64'h22);
        checkOutput("coll_nobyp2", valA2, 64'd0);
        tick();
        applyStimulus(4'd4, 4'd4, NONE, 64'd0, NONE, 64'd0, 1'b0);
        #1;
        checkOutput("coll_rd1", valA1, 64'h22);
        checkOutput("coll_rd2", valA2, 64'h22);
        checkOutput("coll_cnt1", {32'd0, cnt1}, 64'd2);
        checkOutput("coll_cnt2", {32'd0, cnt2}, 64'd2);

        // Dual write held off by the stall; no bypass is allowed either.
        applyStimulus(4'd1, 4'd2, 4'd1, 64'hAA, 4'd2, 64'hBB, 1'b1);
        #1;
        checkOutput("stall_nobypA1", valA1, 64'd1);
        checkOutput("stall_nobypB1", valB1, 64'd2);
        tick();
        applyStimulus(4'd1, 4'd2, NONE, 64'd0, NONE, 64'd0, 1'b0);
        #1;
        checkOutput("stall_rdA1", valA1, 64'd1);
        checkOutput("stall_rdB1", valB1, 64'd2);
        checkOutput("stall_rdA2", valA2, 64'd0);
        checkOutput("stall_cnt1", {32'd0, cnt1}, 64'd2);
        checkOutput("stall_cnt2", {32'd0, cnt2}, 64'd2);

        // The same dual write with the stall released.
        applyStimulus(4'd1, 4'd2, 4'd1, 64'hAA, 4'd2, 64'hBB, 1'b0);
        #1;
        checkOutput("dual_bypA1", valA1, 64'hAA);
        checkOutput("dual_bypB1", valB1, 64'hBB);
        tick();
        applyStimulus(4'd1, 4'd2, NONE, 64'd0, NONE, 64'd0, 1'b0);
        #1;
        checkOutput("dual_rdA1", valA1, 64'hAA);
        checkOutput("dual_rdB1", valB1, 64'hBB);
        checkOutput("dual_rdA2", valA2, 64'hAA);
        checkOutput("dual_rdB2", valB2, 64'hBB);
        checkOutput("dual_cnt1", {32'd0, cnt1}, 64'd4);
        checkOutput("dual_cnt2", {32'd0, cnt2}, 64'd4);

        // NONE on E; index 13 on M (valid for dut1, out of range for dut2).
        applyStimulus(4'd13, NONE, NONE, 64'h77, 4'd13, 64'h99, 1'b0);
        #1;
        checkOutput("oor_byp1", valA1, 64'h99);
        checkOutput("oor_none1", valB1, 64'd0);
        checkOutput("oor_rd2", valA2, 64'd0);
        tick();
        applyStimulus(4'd13, NONE, NONE, 64'd0, NONE, 64'd0, 1'b0);
        #1;
        checkOutput("oor_rd1", valA1, 64'h99);
        checkOutput("oor_after2", valA2, 64'd0);
        checkOutput("oor_cnt1", {32'd0, cnt1}, 64'd5);
        checkOutput("oor_cnt2", {32'd0, cnt2}, 64'd4);

        // Boundary at NREG=12: index 12 is dropped by dut2, index 11 is kept.
        applyStimulus(4'd12, 4'd11, 4'd12, 64'h123, 4'd11, 64'h456, 1'b0);
        tick();
        applyStimulus(4'd12, 4'd11, NONE, 64'd0, NONE, 64'd0, 1'b0);
        #1;
        checkOutput("bnd_rdA1", valA1, 64'h123);
        checkOutput("bnd_rdB1", valB1, 64'h456);
        checkOutput("bnd_rdA2", valA2, 64'd0);
        checkOutput("bnd_rdB2", valB2, 64'h456);
        checkOutput("bnd_cnt1", {32'd0, cnt1}, 64'd7);
        checkOutput("bnd_cnt2", {32'd0, cnt2}, 64'd5);

        // Asynchronous reset asserted while a write to register 5 is pending.
        applyStimulus(4'd5, 4'd3, 4'd5, 64'h55, NONE, 64'd0, 1'b0);
        #1;
        checkOutput("arst_pre_byp1", valA1, 64'h55);
        rst = 1'b1;
        #1;
        checkOutput("arst_rdA1", valA1, 64'd5);
        checkOutput("arst_rdB1", valB1, 64'd3);
        checkOutput("arst_rdB2", valB2, 64'd0);
        checkOutput("arst_cnt1", {32'd0, cnt1}, 64'd0);
        tick();
        checkOutput("arst_hold1", valA1, 64'd5);
        checkOutput("arst_hold2", valA2, 64'd0);
        checkOutput("arst_holdcnt1", {32'd0, cnt1}, 64'd0);
        checkOutput("arst_holdcnt2", {32'd0, cnt2}, 64'd0);
        applyStimulus(4'd0, 4'd14, NONE, 64'd0, NONE, 64'd0, 1'b0);
        rst = 1'b0;

        // After reset, write index 0 on E and index 14 on M (14 is out of range for dut2).
        tick();
        applyStimulus(4'd0, 4'd14, 4'd0, 64'h1234_5678_9ABC_DEF0, 4'd14, 64'hFEED, 1'b0);
        tick();
        applyStimulus(4'd0, 4'd14, NONE, 64'd0, NONE, 64'd0, 1'b0);
        #1;
        checkOutput("post_rdA1", valA1, 64'h1234_5678_9ABC_DEF0);
        checkOutput("post_rdB1", valB1, 64'hFEED);
        checkOutput("post_rdA2", valA2, 64'h1234_5678_9ABC_DEF0);
        checkOutput("post_rdB2", valB2, 64'd0);
        checkOutput("post_cnt1", {32'd0, cnt1}, 64'd2);
        checkOutput("post_cnt2", {32'd0, cnt2}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
